// File: rtl/jtag_dr_engine.sv
// Virtual JTAG data-register engine: bypass, status, command-write and
// response-read registers behind one shared shift register.
module jtag_dr_engine #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            ir_in,
   input  logic                  tdi,
   input  logic                  virtual_state_cdr,
   input  logic                  virtual_state_sdr,
   input  logic                  virtual_state_udr,
   output logic                  tdo,
   output logic [1:0]            ir_out,
   output logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] rsp_data,
   input  logic                  rsp_valid,
   output logic                  rsp_ready
);

   localparam logic [1:0] IR_STATUS = 2'd1;
   localparam logic [1:0] IR_CMD    = 2'd2;
   localparam logic [1:0] IR_RSP    = 2'd3;
   localparam int unsigned STATUS_LEN = 8;

   logic [DATA_WIDTH-1:0] sr;
   logic [DATA_WIDTH-1:0] sr_capture;
   logic [DATA_WIDTH-1:0] sr_shift;
   logic [DATA_WIDTH-1:0] rsp_buf;
   logic                  rsp_held;
   logic                  overflow;
   logic                  do_update;
   logic                  cmd_update;
   logic                  rsp_update;
   logic                  status_update;
   logic                  rsp_take;

   // Capture value and one-bit shift for the register selected by ir_in
   always_comb begin
      sr_capture = '0;
      sr_shift   = sr;
      case (ir_in)
         IR_STATUS: begin
            sr_capture[2:0]          = {overflow, rsp_held, cmd_valid};
            sr_shift[STATUS_LEN-1:0] = {tdi, sr[STATUS_LEN-1:1]};
         end
         IR_CMD: begin
            sr_shift = {tdi, sr[DATA_WIDTH-1:1]};
         end
         IR_RSP: begin
            sr_capture = rsp_buf;
            sr_shift   = {tdi, sr[DATA_WIDTH-1:1]};
         end
         default: begin
            sr_shift[0] = tdi;
         end
      endcase
   end

   // Update only counts when neither higher-priority strobe is present
   assign do_update     = virtual_state_udr && !virtual_state_cdr && !virtual_state_sdr;
   assign cmd_update    = do_update && (ir_in == IR_CMD);
   assign rsp_update    = do_update && (ir_in == IR_RSP);
   assign status_update = do_update && (ir_in == IR_STATUS);
   assign rsp_take      = rsp_valid && !rsp_held;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr        <= '0;
         cmd_data  <= '0;
         cmd_valid <= 1'b0;
         rsp_buf   <= '0;
         rsp_held  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (virtual_state_cdr) begin
            sr <= sr_capture;
         end else if (virtual_state_sdr) begin
            sr <= sr_shift;
         end

         // A same-cycle accept frees the slot, so the new word may replace it
         if (cmd_update) begin
            if (!cmd_valid || cmd_ready) begin
               cmd_data  <= sr;
               cmd_valid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
         end

         if (status_update && sr[2]) begin
            overflow <= 1'b0;
         end

         if (rsp_take) begin
            rsp_buf  <= rsp_data;
            rsp_held <= 1'b1;
         end else if (rsp_update) begin
            rsp_held <= 1'b0;
         end
      end
   end

   assign tdo       = sr[0];
   assign ir_out    = {rsp_held, cmd_valid};
   assign rsp_ready = !rsp_held;

endmodule

// File: tb/tb_jtag_dr_engine.sv
// Self-checking bench for jtag_dr_engine: directed scans plus a randomized
// operation mix checked against a register-level reference model.
module tb_jtag_dr_engine;

   localparam int unsigned DW = 32;
   localparam logic [1:0] IR_BYPASS = 2'd0;
   localparam logic [1:0] IR_STATUS = 2'd1;
   localparam logic [1:0] IR_CMD    = 2'd2;
   localparam logic [1:0] IR_RSP    = 2'd3;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    ir_in;
   logic          tdi;
   logic          cdr;
   logic          sdr;
   logic          udr;
   logic          tdo;
   logic [1:0]    ir_out;
   logic [DW-1:0] cmd_data;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_valid;
   logic          rsp_ready;

   int total = 0;
   int bad   = 0;

   jtag_dr_engine #(.DATA_WIDTH(DW)) dut (
      .clk               (clk),
      .reset             (reset),
      .ir_in             (ir_in),
      .tdi               (tdi),
      .virtual_state_cdr (cdr),
      .virtual_state_sdr (sdr),
      .virtual_state_udr (udr),
      .tdo               (tdo),
      .ir_out            (ir_out),
      .cmd_data          (cmd_data),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .rsp_data          (rsp_data),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic do_reset();
      ir_in = IR_BYPASS; tdi = 1'b0; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Capture, n shift cycles (LSB first), optional update; cmd_ready=rdy only on the update cycle
   task automatic scan(input logic [1:0] ir, input int n, input logic [DW-1:0] din,
                       input bit upd, input bit rdy, output logic [DW-1:0] dout);
      @(negedge clk);
      ir_in = ir; cdr = 1'b1;
      @(negedge clk);
      cdr = 1'b0; sdr = 1'b1;
      dout = '0;
      for (int i = 0; i < n; i++) begin
         tdi = din[i];
         dout[i] = tdo;
         @(negedge clk);
      end
      sdr = 1'b0; tdi = 1'b0;
      udr = upd;
      cmd_ready = upd ? rdy : 1'b0;
      @(negedge clk);
      udr = 1'b0; cmd_ready = 1'b0;
   endtask

   task automatic offer_rsp(input logic [DW-1:0] d);
      @(negedge clk);
      rsp_data = d; rsp_valid = 1'b1;
      @(negedge clk);
      rsp_valid = 1'b0;
   endtask

   task automatic accept_pulse();
      @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [DW-1:0] d;
      do_reset();
      total++; if (tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
      total++; if (ir_out !== 2'b00) begin bad++; $display("FAIL reset_ir_out got=%b exp=00", ir_out); end
      total++; if (rsp_ready !== 1'b1) begin bad++; $display("FAIL reset_rsp_ready got=%b exp=1", rsp_ready); end
      total++; if (cmd_valid !== 1'b0 || cmd_data !== '0) begin bad++;
         $display("FAIL reset_cmd got=%b/%h exp=0/0", cmd_valid, cmd_data); end
      // build up state: pending command, overflow, held response, then abort a scan
      scan(IR_CMD, DW, 32'h55, 1'b1, 1'b0, d);
      scan(IR_CMD, DW, 32'h66, 1'b1, 1'b0, d);
      offer_rsp(32'hFFFF_FFFF);
      @(negedge clk);
      ir_in = IR_RSP; cdr = 1'b1;
      @(negedge clk);
      cdr = 1'b0; sdr = 1'b1; tdi = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      total++; if (tdo !== 1'b0) begin bad++; $display("FAIL midscan_tdo got=%b exp=0", tdo); end
      total++; if (ir_out !== 2'b00) begin bad++; $display("FAIL midscan_ir_out got=%b exp=00", ir_out); end
      total++; if (rsp_ready !== 1'b1) begin bad++; $display("FAIL midscan_rsp_ready got=%b exp=1", rsp_ready); end
      total++; if (cmd_valid !== 1'b0 || cmd_data !== '0) begin bad++;
         $display("FAIL midscan_cmd got=%b/%h exp=0/0", cmd_valid, cmd_data); end
      sdr = 1'b0; tdi = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      scan(IR_STATUS, 8, '0, 1'b1, 1'b0, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
      scan(IR_RSP, DW, '0, 1'b1, 1'b0, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_rsp_buf got=%h exp=0", d); end
      total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_no_partial got=%b exp=0", cmd_valid); end
   endtask

   task automatic test_cmd_write();
      logic [DW-1:0] d;
      scan(IR_CMD, DW, 32'hDEAD_BEEF, 1'b1, 1'b0, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL cmd_capture got=%h exp=0", d); end
      total++; if (cmd_valid !== 1'b1 || cmd_data !== 32'hDEAD_BEEF) begin bad++;
         $display("FAIL cmd_write got=%b/%h exp=1/deadbeef", cmd_valid, cmd_data); end
      total++; if (ir_out !== 2'b01) begin bad++; $display("FAIL cmd_ir_out got=%b exp=01", ir_out); end
      accept_pulse();
      total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL cmd_accept got=%b exp=0", cmd_valid); end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] d;
      scan(IR_CMD, DW, 32'h1, 1'b1, 1'b0, d);
      scan(IR_CMD, DW, 32'h2, 1'b1, 1'b0, d);
      total++; if (cmd_valid !== 1'b1 || cmd_data !== 32'h1) begin bad++;
         $display("FAIL ovf_keep got=%b/%h exp=1/00000001", cmd_valid, cmd_data); end
      scan(IR_STATUS, 8, 32'h0, 1'b1, 1'b0, d);
      total++; if (d !== 32'h05) begin bad++; $display("FAIL ovf_status got=%h exp=05", d); end
      scan(IR_STATUS, 8, 32'h04, 1'b1, 1'b0, d);
      total++; if (d !== 32'h05) begin bad++; $display("FAIL ovf_status_hold got=%h exp=05", d); end
      scan(IR_STATUS, 8, 32'h0, 1'b1, 1'b0, d);
      total++; if (d !== 32'h01) begin bad++; $display("FAIL ovf_clear got=%h exp=01", d); end
      accept_pulse();
   endtask

   task automatic test_response();
      logic [DW-1:0] d;
      offer_rsp(32'h1234_5678);
      total++; if (rsp_ready !== 1'b0 || ir_out !== 2'b10) begin bad++;
         $display("FAIL rsp_held got=%b/%b exp=0/10", rsp_ready, ir_out); end
      // second offer while held must be ignored, then taken right after the read
      @(negedge clk);
      rsp_data = 32'hCAFE_0001; rsp_valid = 1'b1;
      scan(IR_RSP, DW, '0, 1'b1, 1'b0, d);
      total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL rsp_read got=%h exp=12345678", d); end
      total++; if (rsp_ready !== 1'b1) begin bad++; $display("FAIL rsp_consumed got=%b exp=1", rsp_ready); end
      @(negedge clk);
      rsp_valid = 1'b0;
      total++; if (rsp_ready !== 1'b0) begin bad++; $display("FAIL rsp_retake got=%b exp=0", rsp_ready); end
      scan(IR_RSP, DW, '0, 1'b1, 1'b0, d);
      total++; if (d !== 32'hCAFE_0001) begin bad++; $display("FAIL rsp_read2 got=%h exp=cafe0001", d); end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] d;
      scan(IR_BYPASS, 4, 32'b1101, 1'b1, 1'b0, d);
      total++; if (d !== 32'b1010) begin bad++; $display("FAIL bypass got=%b exp=1010", d[3:0]); end
   endtask

   task automatic test_simultaneous();
      logic [DW-1:0] d;
      scan(IR_CMD, DW, 32'h77, 1'b1, 1'b0, d);
      scan(IR_CMD, DW, 32'hA5, 1'b1, 1'b1, d);
      total++; if (cmd_valid !== 1'b1 || cmd_data !== 32'hA5) begin bad++;
         $display("FAIL simul_cmd got=%b/%h exp=1/000000a5", cmd_valid, cmd_data); end
      scan(IR_STATUS, 8, '0, 1'b1, 1'b0, d);
      total++; if (d !== 32'h01) begin bad++; $display("FAIL simul_status got=%h exp=01", d); end
      accept_pulse();
   endtask

   task automatic test_random();
      logic [DW-1:0] d;
      logic [DW-1:0] w;
      logic [DW-1:0] exp;
      bit            rdy;
      int            n;
      bit            m_valid;
      bit            m_held;
      bit            m_ovf;
      logic [DW-1:0] m_data;
      logic [DW-1:0] m_buf;
      do_reset();
      m_valid = 0; m_held = 0; m_ovf = 0; m_data = '0; m_buf = '0;
      for (int it = 0; it < 80; it++) begin
         w = DW'($urandom);
         case ($urandom_range(0, 5))
            0: begin
               rdy = bit'($urandom_range(0, 1));
               scan(IR_CMD, DW, w, 1'b1, rdy, d);
               total++; if (d !== '0) begin bad++; $display("FAIL rnd_cmd_cap it=%0d got=%h exp=0", it, d); end
               if (!m_valid || rdy) begin m_data = w; m_valid = 1; end
               else m_ovf = 1;
            end
            1: begin
               w = w & 32'hFF;
               scan(IR_STATUS, 8, w, 1'b1, 1'b0, d);
               exp = {29'd0, m_ovf, m_held, m_valid};
               total++; if (d !== exp) begin bad++; $display("FAIL rnd_status it=%0d got=%h exp=%h", it, d, exp); end
               if (w[2]) m_ovf = 0;
            end
            2: begin
               offer_rsp(w);
               if (!m_held) begin m_buf = w; m_held = 1; end
            end
            3: begin
               scan(IR_RSP, DW, w, 1'b1, 1'b0, d);
               total++; if (d !== m_buf) begin bad++; $display("FAIL rnd_rsp it=%0d got=%h exp=%h", it, d, m_buf); end
               m_held = 0;
            end
            4: begin
               accept_pulse();
               m_valid = 0;
            end
            default: begin
               n = $urandom_range(1, 8);
               scan(IR_BYPASS, n, w, 1'b1, 1'b0, d);
               exp = (w << 1) & ((32'd1 << n) - 32'd1);
               total++; if (d !== exp) begin bad++; $display("FAIL rnd_bypass it=%0d got=%h exp=%h", it, d, exp); end
            end
         endcase
         total++; if (ir_out !== {m_held, m_valid} || rsp_ready !== !m_held) begin bad++;
            $display("FAIL rnd_flags it=%0d got=%b/%b exp=%b/%b", it, ir_out, rsp_ready, {m_held, m_valid}, !m_held); end
         if (m_valid) begin
            total++; if (cmd_data !== m_data) begin bad++;
               $display("FAIL rnd_cmd_data it=%0d got=%h exp=%h", it, cmd_data, m_data); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_cmd_write();
      test_overflow();
      test_response();
      test_bypass();
      test_simultaneous();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
